// File: rtl/instruction_fetch_unit_if.sv
// Fetch unit bus bundle: redirect, imem request/response, decode output.
// master = fetch unit side, slave = memory/decode side.
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  redirect_i;
  logic [DATA_WIDTH-1:0] redirect_pc_i;
  logic                  imem_req_valid_o;
  logic                  imem_req_ready_i;
  logic [DATA_WIDTH-1:0] imem_addr_o;
  logic                  imem_rsp_valid_i;
  logic [DATA_WIDTH-1:0] imem_rsp_data_i;
  logic                  instr_valid_o;
  logic                  instr_ready_i;
  logic [DATA_WIDTH-1:0] Instruction_bus_o;
  logic [6:0]            op_o;
  logic [DATA_WIDTH-1:0] pc_o;

  modport master (
    input  redirect_i,
    input  redirect_pc_i,
    output imem_req_valid_o,
    input  imem_req_ready_i,
    output imem_addr_o,
    input  imem_rsp_valid_i,
    input  imem_rsp_data_i,
    output instr_valid_o,
    input  instr_ready_i,
    output Instruction_bus_o,
    output op_o,
    output pc_o
  );

  modport slave (
    output redirect_i,
    output redirect_pc_i,
    input  imem_req_valid_o,
    output imem_req_ready_i,
    input  imem_addr_o,
    output imem_rsp_valid_i,
    output imem_rsp_data_i,
    input  instr_valid_o,
    output instr_ready_i,
    input  Instruction_bus_o,
    input  op_o,
    input  pc_o
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, credit-limited imem requests, in-order
// instruction buffer, redirect flush with response dropping.
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input logic                      clk,
  input logic                      reset,
  instruction_fetch_unit_if.master bus
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [DW-1:0] pc;
    logic [DW-1:0] instr;
  } entry_t;

  state_t        state_q, state_d;
  logic [DW-1:0] fetch_pc_q;
  logic [DW-1:0] rsp_pc_q;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  entry_t        buf_q [FIFO_DEPTH];

  logic [CW-1:0] credits;
  logic [DW-1:0] target;
  logic          req_valid;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic          out_valid;
  entry_t        head;

  // in_flight counts every outstanding response, dropped ones too
  assign credits   = CW'(FIFO_DEPTH) - in_flight_q - count_q;
  assign target    = bus.redirect_pc_i & ~DW'(3);
  assign req_valid = reset && (state_q == RUN)
                     && (credits != '0) && !bus.redirect_i;
  assign req_fire  = req_valid && bus.imem_req_ready_i;
  assign push      = bus.imem_rsp_valid_i && (drop_q == '0)
                     && !bus.redirect_i;
  assign out_valid = (count_q != '0) && (state_q == RUN);
  assign pop       = out_valid && bus.instr_ready_i
                     && !bus.redirect_i;
  assign head      = buf_q[rd_ptr_q];

  assign bus.imem_req_valid_o  = req_valid;
  assign bus.imem_addr_o       = fetch_pc_q;
  assign bus.instr_valid_o     = out_valid;
  assign bus.Instruction_bus_o = out_valid ? head.instr : '0;
  assign bus.op_o              = bus.Instruction_bus_o[6:0];
  assign bus.pc_o              = out_valid ? head.pc : '0;

  // outstanding/drop accounting and RUN/FLUSH transitions
  always_comb begin
    in_flight_d = in_flight_q + CW'(req_fire)
                  - CW'(bus.imem_rsp_valid_i);
    drop_d      = drop_q;
    state_d     = state_q;
    unique case (1'b1)
      bus.redirect_i:
        drop_d = in_flight_d;
      !bus.redirect_i && (drop_q != '0):
        drop_d = drop_q - CW'(bus.imem_rsp_valid_i);
      default: ;
    endcase
    unique case (state_q)
      RUN:
        if (bus.redirect_i && (drop_d != '0))
          state_d = FLUSH;
      FLUSH:
        if (drop_d == '0)
          state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // control state, PCs and buffer pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      in_flight_q <= '0;
      drop_q      <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      if (bus.redirect_i) begin
        fetch_pc_q <= target;
        rsp_pc_q   <= target;
        count_q    <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        if (req_fire)
          fetch_pc_q <= fetch_pc_q + DW'(4);
        if (push) begin
          rsp_pc_q <= rsp_pc_q + DW'(4);
          wr_ptr_q <= wr_ptr_q + PW'(1);
        end
        if (pop)
          rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // buffer storage; contents are qualified by count_q
  always_ff @(posedge clk) begin
    if (push)
      buf_q[wr_ptr_q] <= '{pc: rsp_pc_q,
                           instr: bus.imem_rsp_data_i};
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model with latency,
// epoch-tagged reference model, directed and random phases.
module tb_instruction_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam int          DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instruction_fetch_unit_if #(.DATA_WIDTH(32)) ifc ();

  instruction_fetch_unit #(
    .DATA_WIDTH(32),
    .RESET_PC  (RPC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } out_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  req_t        mq[$];
  out_t        dq[$];
  logic [31:0] m_pc;
  int          epoch;

  logic        d_redir;
  logic [31:0] d_tgt;
  logic        d_mrdy;
  logic        d_irdy;
  int          lat_min;
  int          lat_max;

  logic        fired;
  logic [31:0] fire_addr;
  logic        popped;
  logic [31:0] pop_pc;
  logic        vis;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 60)
        $display("FAIL %s: got %h want %h (cycle %0d)",
                 n, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    dq.delete();
    m_pc = RPC;
    epoch++;
  endtask

  task automatic step();
    int   old_out;
    int   credits;
    logic rv;
    req_t r;
    @(negedge clk);
    cyc++;
    rv = (mq.size() > 0) && (mq[0].due <= cyc);
    ifc.imem_rsp_valid_i = rv;
    if (rv) ifc.imem_rsp_data_i = word(mq[0].addr);
    else    ifc.imem_rsp_data_i = $urandom;
    ifc.redirect_i       = d_redir;
    ifc.redirect_pc_i    = d_tgt;
    ifc.imem_req_ready_i = d_mrdy;
    ifc.instr_ready_i    = d_irdy;
    #1;
    old_out = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) old_out++;
    credits = DEPTH - mq.size() - dq.size();
    chk("req_valid", 32'(ifc.imem_req_valid_o),
        32'(old_out == 0 && credits > 0 && !d_redir));
    if (ifc.imem_req_valid_o)
      chk("imem_addr", ifc.imem_addr_o, m_pc);
    chk("instr_valid", 32'(ifc.instr_valid_o), 32'(dq.size() > 0));
    if (dq.size() > 0) begin
      chk("pc_o", ifc.pc_o, dq[0].pc);
      chk("instr", ifc.Instruction_bus_o, dq[0].instr);
      chk("op_o", 32'(ifc.op_o), 32'(dq[0].instr[6:0]));
    end else begin
      chk("pc_o_idle", ifc.pc_o, 32'h0);
      chk("instr_idle", ifc.Instruction_bus_o, 32'h0);
    end
    vis    = ifc.instr_valid_o;
    popped = (dq.size() > 0) && d_irdy && !d_redir;
    pop_pc = ifc.pc_o;
    if (popped) void'(dq.pop_front());
    if (rv) begin
      r = mq.pop_front();
      if (r.epoch == epoch && !d_redir)
        dq.push_back('{pc: r.addr, instr: word(r.addr)});
    end
    fired     = ifc.imem_req_valid_o && d_mrdy;
    fire_addr = ifc.imem_addr_o;
    if (fired) begin
      mq.push_back('{addr: m_pc, epoch: epoch,
                     due: cyc + int'($urandom_range(lat_max, lat_min))});
      m_pc += 32'd4;
    end
    if (d_redir) begin
      epoch++;
      dq.delete();
      m_pc = d_tgt & ~32'h3;
    end
  endtask

  task automatic drain(input int n);
    d_redir = 1'b0;
    d_mrdy  = 1'b0;
    d_irdy  = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a[3];
    int          n;
    int          fc;
    int          vc;
    logic        got;
    logic [31:0] hold_addr;

    d_redir = 1'b0; d_tgt = '0; d_mrdy = 1'b0; d_irdy = 1'b0;
    lat_min = 1; lat_max = 1;
    ifc.redirect_i       = 1'b0;
    ifc.redirect_pc_i    = '0;
    ifc.imem_req_ready_i = 1'b0;
    ifc.imem_rsp_valid_i = 1'b0;
    ifc.imem_rsp_data_i  = '0;
    ifc.instr_ready_i    = 1'b0;
    epoch = 0;
    model_reset();

    #1;
    chk("rst_req_valid", 32'(ifc.imem_req_valid_o), 32'h0);
    chk("rst_instr_valid", 32'(ifc.instr_valid_o), 32'h0);
    chk("rst_bus", ifc.Instruction_bus_o, 32'h0);
    chk("rst_op", 32'(ifc.op_o), 32'h0);
    chk("rst_pc", ifc.pc_o, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // sequential fetch, 1-cycle memory
    d_mrdy = 1'b1; d_irdy = 1'b1;
    n = 0; fc = -1; vc = -1; got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fired && n < 3) begin
        a[n] = fire_addr;
        if (n == 0) fc = cyc;
        n++;
      end
      if (vis && vc < 0) vc = cyc;
      if (popped && !got) begin
        got = 1'b1;
        chk("first_pc_o", pop_pc, 32'h0040_0000);
      end
    end
    chk("addr0", a[0], 32'h0040_0000);
    chk("addr1", a[1], 32'h0040_0004);
    chk("addr2", a[2], 32'h0040_0008);
    chk("rsp_out_latency", 32'(vc - fc), 32'd2);
    chk("first_pop_seen", 32'(got), 32'h1);

    // decode stalled: exactly DEPTH requests
    drain(6);
    d_irdy = 1'b0; d_mrdy = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fired) n++;
    end
    chk("stall_req_count", 32'(n), 32'd2);
    chk("stall_req_valid", 32'(ifc.imem_req_valid_o), 32'h0);
    d_irdy = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (fired) n++;
    end
    chk("resume_req_seen", 32'(n >= 4), 32'h1);

    // memory backpressure: address and valid held
    drain(6);
    hold_addr = m_pc;
    d_mrdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", 32'(ifc.imem_req_valid_o), 32'h1);
      chk("hold_addr", ifc.imem_addr_o, hold_addr);
    end

    // redirect with two requests in flight
    drain(4);
    lat_min = 4; lat_max = 4;
    d_mrdy = 1'b1;
    n = 0;
    for (int i = 0; i < 8 && n < 2; i++) begin
      step();
      if (fired) n++;
    end
    chk("two_in_flight", 32'(mq.size()), 32'd2);
    d_redir = 1'b1; d_tgt = 32'h0040_0103;
    step();
    d_redir = 1'b0;
    lat_min = 1; lat_max = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (fired) begin
        got = 1'b1;
        chk("redir_addr", fire_addr, 32'h0040_0100);
      end
    end
    chk("redir_fire_seen", 32'(got), 32'h1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (popped) begin
        got = 1'b1;
        chk("redir_pc_o", pop_pc, 32'h0040_0100);
      end
    end
    chk("redir_pop_seen", 32'(got), 32'h1);

    // address wrap
    drain(4);
    d_redir = 1'b1; d_tgt = 32'hFFFF_FFF8;
    step();
    d_redir = 1'b0; d_mrdy = 1'b1;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      step();
      if (fired) begin
        a[n] = fire_addr;
        n++;
      end
    end
    chk("wrap_a0", a[0], 32'hFFFF_FFF8);
    chk("wrap_a1", a[1], 32'hFFFF_FFFC);
    chk("wrap_a2", a[2], 32'h0000_0000);

    // async reset with buffer full
    drain(4);
    d_irdy = 1'b0; d_mrdy = 1'b1;
    repeat (6) step();
    chk("full_valid", 32'(ifc.instr_valid_o), 32'h1);
    chk("full_count", 32'(dq.size()), 32'd2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_instr_valid", 32'(ifc.instr_valid_o), 32'h0);
    chk("arst_bus", ifc.Instruction_bus_o, 32'h0);
    chk("arst_op", 32'(ifc.op_o), 32'h0);
    chk("arst_pc", ifc.pc_o, 32'h0);
    chk("arst_req_valid", 32'(ifc.imem_req_valid_o), 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    d_irdy = 1'b1; d_mrdy = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (fired) begin
        got = 1'b1;
        chk("restart_addr", fire_addr, 32'h0040_0000);
      end
    end
    chk("restart_seen", 32'(got), 32'h1);

    // randomized traffic
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      d_redir = ($urandom_range(15, 0) == 0);
      if ($urandom_range(7, 0) == 0)
        d_tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else
        d_tgt = $urandom;
      d_mrdy = ($urandom_range(3, 0) != 0);
      d_irdy = ($urandom_range(9, 0) < 7);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
